subneg_core_p: RTL and testbench

SUBNEG_CORE_P -- requirements
Module: subneg_core_p

---
 rtl/subneg_core_p.sv | 212 +++++++++++++++++++++
 tb/tb_subneg_core_p.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/subneg_core_p.sv
// subneg_core_p -- single-instruction (SUBNEG) processor core.
//
// Each instruction is three words A, B, C at PC, PC+1, PC+2:
//   mem[B] <= mem[B] - mem[A]; if (mem[A] > mem[B]) PC <= C else PC <= PC+3.
// Memory is an external SRAM on a shared bus with an external address latch.
// Every bus access takes four cycles, and every output is registered, so the
// value a state assigns is visible on the pins during the following state.
// Writing to B == OUT_ADDR pulses out_stb instead of writing memory.
// A taken branch to its own address halts the core until reset.
//
// Optional feature: define SUBNEG_IN_PORT_EN to serve A == IN_ADDR from
// in_data instead of memory (in_ack pulses when the value is consumed).
module subneg_core_p #(
    parameter int unsigned   DW       = 8,
    parameter logic [DW-1:0] OUT_ADDR = {DW{1'b1}},
    parameter bit            SIGNED   = 1'b0,
    parameter logic [DW-1:0] IN_ADDR  = {{(DW-1){1'b1}}, 1'b0}
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [DW-1:0] bus_in,
    output logic [DW-1:0] bus_out,
    output logic [DW-1:0] bus_oe,
    output logic          mem_latch,
    output logic          mem_oe_n,
    output logic          mem_we_n,
    output logic          out_stb,
    output logic          halted,
    output logic [4:0]    dbg_state,
    input  logic [DW-1:0] in_data,
    output logic          in_ack
);

    // Read phases occupy states 0..19 in groups of four; the group selects
    // the address and the destination register of the access.
    localparam logic [4:0] S_FA0  = 5'd0;
    localparam logic [4:0] S_WR0  = 5'd20;
    localparam logic [4:0] S_WR1  = 5'd21;
    localparam logic [4:0] S_WR2  = 5'd22;
    localparam logic [4:0] S_WR3  = 5'd23;
    localparam logic [4:0] S_WR4  = 5'd24;
    localparam logic [4:0] S_HALT = 5'd25;

    localparam logic [2:0] G_FA = 3'd0;
    localparam logic [2:0] G_FB = 3'd1;
    localparam logic [2:0] G_FC = 3'd2;
    localparam logic [2:0] G_RA = 3'd3;

    localparam logic [DW-1:0] C_ONE   = DW'(1);
    localparam logic [DW-1:0] C_TWO   = DW'(2);
    localparam logic [DW-1:0] C_THREE = DW'(3);

    logic [4:0]    r_state;
    logic [DW-1:0] r_pc;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_c;
    logic [DW-1:0] r_va;
    logic [DW-1:0] r_vb;
    logic [DW-1:0] r_bus_out;
    logic          r_latch;
    logic          r_oe_n;
    logic          r_we_n;
    logic          r_out_stb;
    logic          r_halted;
    logic          r_in_ack;
    logic          r_self_loop;

    logic [2:0]    w_group;
    logic [1:0]    w_phase;
    logic [DW-1:0] w_addr;
    logic          w_taken;
    logic          w_in_sel;

    assign w_group = r_state[4:2];
    assign w_phase = r_state[1:0];

    // Operands and addresses are plain bit patterns; only the branch
    // compare cares about signedness. All sums wrap naturally at DW bits.
    assign w_taken = SIGNED ? ($signed(r_va) > $signed(r_vb)) : (r_va > r_vb);

`ifdef SUBNEG_IN_PORT_EN
    assign w_in_sel = (w_group == G_RA) && (r_a == IN_ADDR);
`else
    logic w_unused_cfg;
    assign w_in_sel     = 1'b0;
    assign w_unused_cfg = ^IN_ADDR;
`endif

    // Bus address for the read access of the current state group.
    always_comb begin
        // NOTE: the default assignment comes first so every path assigns
        // w_addr and no latch is inferred.
        w_addr = r_pc;
        case (w_group)
            G_FB:    w_addr = r_pc + C_ONE;
            G_FC:    w_addr = r_pc + C_TWO;
            G_RA:    w_addr = r_a;
            3'd4:    w_addr = r_b;
            default: w_addr = r_pc;
        endcase
    end

    // Bus sequencer: one state per bus cycle, reads then the write-back.
    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            r_state     <= S_FA0;
            r_pc        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_va        <= '0;
            r_vb        <= '0;
            r_bus_out   <= '0;
            r_latch     <= 1'b0;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_out_stb   <= 1'b0;
            r_halted    <= 1'b0;
            r_in_ack    <= 1'b0;
            r_self_loop <= 1'b0;
        end else begin
            r_in_ack <= 1'b0;
            case (r_state)
                S_WR0: begin
                    r_bus_out <= r_b;
                    r_latch   <= 1'b0;
                    r_oe_n    <= 1'b1;
                    r_state   <= S_WR1;
                end
                S_WR1: begin
                    r_latch <= 1'b1;
                    r_state <= S_WR2;
                end
                S_WR2: begin
                    r_bus_out <= r_vb - r_va;
                    r_state   <= S_WR3;
                end
                S_WR3: begin
                    if (r_b != OUT_ADDR) r_we_n <= 1'b0;
                    else                 r_out_stb <= 1'b1;
                    r_pc        <= w_taken ? r_c : r_pc + C_THREE;
                    r_self_loop <= w_taken && (r_c == r_pc);
                    r_state     <= S_WR4;
                end
                S_WR4: begin
                    r_we_n    <= 1'b1;
                    r_out_stb <= 1'b0;
                    r_state   <= r_self_loop ? S_HALT : S_FA0;
                end
                S_HALT: begin
                    r_halted  <= 1'b1;
                    r_oe_n    <= 1'b0;
                    r_latch   <= 1'b0;
                    r_we_n    <= 1'b1;
                    r_out_stb <= 1'b0;
                end
                default: begin
                    if (r_state > S_HALT) begin
                        r_state <= S_FA0;
                    end else begin
                        case (w_phase)
                            2'd0: begin
                                r_latch   <= 1'b0;
                                r_oe_n    <= 1'b1;
                                r_we_n    <= 1'b1;
                                r_out_stb <= 1'b0;
                                if (r_state != S_FA0 || run) begin
                                    r_bus_out <= w_addr;
                                    r_state   <= r_state + 5'd1;
                                end
                            end
                            2'd1: begin
                                if (!w_in_sel) r_latch <= 1'b1;
                                r_state <= r_state + 5'd1;
                            end
                            2'd2: begin
                                if (w_in_sel) r_in_ack <= 1'b1;
                                else          r_oe_n   <= 1'b0;
                                r_state <= r_state + 5'd1;
                            end
                            default: begin
                                case (w_group)
                                    G_FA:    r_a  <= bus_in;
                                    G_FB:    r_b  <= bus_in;
                                    G_FC:    r_c  <= bus_in;
                                    G_RA:    r_va <= w_in_sel ? in_data : bus_in;
                                    default: r_vb <= bus_in;
                                endcase
                                r_state <= r_state + 5'd1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus_out   = r_bus_out;
    assign bus_oe    = {DW{r_oe_n}};
    assign mem_latch = r_latch;
    assign mem_oe_n  = r_oe_n;
    assign mem_we_n  = r_we_n;
    assign out_stb   = r_out_stb;
    assign halted    = r_halted;
    assign dbg_state = r_state;
    assign in_ack    = r_in_ack;

endmodule

// File: tb/tb_subneg_core_p.sv
// tb_subneg_core_p -- bench for subneg_core_p.
// Core 0 is the unsigned build, core 1 the signed build; each has its own
// SRAM and address-latch model. Latched bus addresses and out_stb values of
// core 0 are checked against a scoreboard filled when a program is loaded.
`timescale 1ns/1ps
module tb_subneg_core_p;

    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          run;
    logic [DW-1:0] in_data = 8'hA5;

    logic [DW-1:0] bus_in    [2];
    logic [DW-1:0] bus_out   [2];
    logic [DW-1:0] bus_oe    [2];
    logic          mem_latch [2];
    logic          mem_oe_n  [2];
    logic          mem_we_n  [2];
    logic          out_stb   [2];
    logic          halted    [2];
    logic [4:0]    dbg_state [2];
    logic          in_ack    [2];

    logic [DW-1:0] mem [2][256];
    logic [DW-1:0] lat [2];
    logic          prev_latch [2];

    for (genvar g = 0; g < 2; g++) begin : g_core
        subneg_core_p #(.DW(DW), .SIGNED(g == 1)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .run       (run),
            .bus_in    (bus_in[g]),
            .bus_out   (bus_out[g]),
            .bus_oe    (bus_oe[g]),
            .mem_latch (mem_latch[g]),
            .mem_oe_n  (mem_oe_n[g]),
            .mem_we_n  (mem_we_n[g]),
            .out_stb   (out_stb[g]),
            .halted    (halted[g]),
            .dbg_state (dbg_state[g]),
            .in_data   (in_data),
            .in_ack    (in_ack[g])
        );
        assign bus_in[g] = mem_oe_n[g] ? '0 : mem[g][lat[g]];
    end

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_addr [$];
    logic [DW-1:0] exp_out  [$];
    int            we_low   [2];
    int            stb_cnt;
    bit            chk_on;

    // One clock: SRAM/latch model for both cores plus scoreboard compares.
    task automatic step();
        logic [DW-1:0] e;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (mem_latch[k] === 1'b1 && prev_latch[k] !== 1'b1) begin
                lat[k] = bus_out[k];
                if (k == 0 && chk_on) begin
                    total++;
                    if (exp_addr.size() == 0) begin
                        bad++;
                        $display("FAIL bus_addr: latched %02h, no latch required", bus_out[0]);
                    end else begin
                        e = exp_addr.pop_front();
                        if (bus_out[0] !== e) begin
                            bad++;
                            $display("FAIL bus_addr: latched %02h, required %02h", bus_out[0], e);
                        end
                    end
                end
            end
            prev_latch[k] = mem_latch[k];
            if (mem_we_n[k] === 1'b0) begin
                mem[k][lat[k]] = bus_out[k];
                we_low[k]++;
            end
        end
        if (out_stb[0] === 1'b1) begin
            stb_cnt++;
            total++;
            if (exp_out.size() == 0) begin
                bad++;
                $display("FAIL out_stb: strobe with bus_out=%02h, none required", bus_out[0]);
            end else begin
                e = exp_out.pop_front();
                if (bus_out[0] !== e || dbg_state[0] !== 5'd24) begin
                    bad++;
                    $display("FAIL out_stb: bus_out=%02h state=%0d, required %02h in state 24",
                             bus_out[0], dbg_state[0], e);
                end
            end
        end
    endtask

    // Hold both cores in reset (run=1) for two cycles and clear the memories.
    task automatic start_test();
        reset = 1'b1;
        run   = 1'b1;
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) mem[k][i] = '0;
            we_low[k] = 0;
        end
        exp_addr.delete();
        exp_out.delete();
        stb_cnt = 0;
        chk_on  = 1'b1;
    endtask

    task automatic go();
        reset = 1'b0;
        run   = 1'b1;
    endtask

    task automatic push3(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                         input logic [DW-1:0] a2);
        exp_addr.push_back(a0);
        exp_addr.push_back(a1);
        exp_addr.push_back(a2);
    endtask

    // Run one instruction of core 0 until it is back in state 0.
    task automatic run_instr(input int exp_cyc, input string name);
        int n;
        n = 0;
        while (n < 60) begin
            step();
            n++;
            if (dbg_state[0] === 5'd0) break;
        end
        total++;
        if (n != exp_cyc) begin
            bad++;
            $display("FAIL %s_cycles: back in state 0 after %0d cycles, required %0d", name, n, exp_cyc);
        end
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_addr.size() != 0) begin
            bad++;
            $display("FAIL %s_drained: %0d bus addresses still pending, required 0", name, exp_addr.size());
            exp_addr.delete();
        end
    endtask

    // The next latched fetch address reveals the program counter.
    task automatic check_fetch_pc(input logic [DW-1:0] pc, input string name);
        int n;
        n = 0;
        exp_addr.push_back(pc);
        run = 1'b1;
        while (exp_addr.size() != 0 && n < 12) begin
            step();
            n++;
        end
        total++;
        if (exp_addr.size() != 0) begin
            bad++;
            $display("FAIL %s: no fetch within %0d cycles, required address %02h", name, n, pc);
            exp_addr.delete();
        end
        run    = 1'b0;
        chk_on = 1'b0;
    endtask

    task automatic test_reset();
        start_test();
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({dbg_state[k], bus_out[k], bus_oe[k], mem_latch[k], mem_oe_n[k],
                 mem_we_n[k], out_stb[k], halted[k], in_ack[k]} !==
                {5'd0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL reset_outputs core%0d: state=%0d bus_out=%02h oe=%02h latch=%b oe_n=%b we_n=%b stb=%b halted=%b ack=%b, required 0/00/FF/0/1/1/0/0/0",
                         k, dbg_state[k], bus_out[k], bus_oe[k], mem_latch[k], mem_oe_n[k],
                         mem_we_n[k], out_stb[k], halted[k], in_ack[k]);
            end
        end
        reset = 1'b0;
        run   = 1'b0;
        repeat (3) step();
        total++;
        if ({dbg_state[0], mem_latch[0], mem_oe_n[0], mem_we_n[0], out_stb[0]} !==
            {5'd0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL idle_hold: state=%0d latch=%b oe_n=%b we_n=%b stb=%b, required 0/0/1/1/0",
                     dbg_state[0], mem_latch[0], mem_oe_n[0], mem_we_n[0], out_stb[0]);
        end
    endtask

    task automatic test_basic();
        start_test();
        mem[0][0] = 8'd10; mem[0][1] = 8'd11; mem[0][2] = 8'd20;
        mem[0][10] = 8'd3; mem[0][11] = 8'd5;
        push3(8'd0, 8'd1, 8'd2);
        push3(8'd10, 8'd11, 8'd11);
        go();
        run_instr(25, "basic");
        total++;
        if (mem[0][11] !== 8'd2) begin
            bad++;
            $display("FAIL basic_mem: mem[11]=%02h, required 02", mem[0][11]);
        end
        check_drained("basic");
        check_fetch_pc(8'd3, "basic_pc");
    endtask

    task automatic test_branch_taken();
        start_test();
        mem[0][0] = 8'd10; mem[0][1] = 8'd11; mem[0][2] = 8'd20;
        mem[0][10] = 8'd7; mem[0][11] = 8'd5;
        mem[1][0] = 8'd10; mem[1][1] = 8'd11; mem[1][2] = 8'd20;
        mem[1][10] = 8'hFF; mem[1][11] = 8'd5;
        push3(8'd0, 8'd1, 8'd2);
        push3(8'd10, 8'd11, 8'd11);
        go();
        run_instr(25, "taken");
        total++;
        if (mem[0][11] !== 8'hFE) begin
            bad++;
            $display("FAIL taken_mem: mem[11]=%02h, required FE", mem[0][11]);
        end
        total++;
        if (mem[1][11] !== 8'd6) begin
            bad++;
            $display("FAIL signed_mem: mem[11]=%02h, required 06", mem[1][11]);
        end
        check_drained("taken");
        check_fetch_pc(8'd20, "taken_pc");
        total++;
        if (lat[1] !== 8'd3 || halted[1] !== 1'b0) begin
            bad++;
            $display("FAIL signed_pc: next fetch %02h halted=%b, required 03 and 0", lat[1], halted[1]);
        end
    endtask

    task automatic test_out_port();
        start_test();
        mem[0][0] = 8'd10; mem[0][1] = 8'hFF; mem[0][2] = 8'd20;
        mem[0][10] = 8'd1; mem[0][255] = 8'd9;
        push3(8'd0, 8'd1, 8'd2);
        push3(8'd10, 8'hFF, 8'hFF);
        exp_out.push_back(8'd8);
        go();
        run_instr(25, "out");
        total++;
        if (stb_cnt != 1 || we_low[0] != 0 || mem[0][255] !== 8'd9) begin
            bad++;
            $display("FAIL out_side: strobes=%0d we_low=%0d mem[FF]=%02h, required 1, 0, 09",
                     stb_cnt, we_low[0], mem[0][255]);
        end
        check_drained("out");
        check_fetch_pc(8'd3, "out_pc");
    endtask

    task automatic test_wrap();
        start_test();
        // Jump from 0 to FE (1 > 0), then run the instruction that wraps.
        mem[0][0] = 8'd3; mem[0][1] = 8'd4; mem[0][2] = 8'hFE;
        mem[0][3] = 8'd1; mem[0][4] = 8'd0;
        mem[0][254] = 8'h10; mem[0][255] = 8'h11;
        mem[0][16] = 8'd2; mem[0][17] = 8'd5;
        push3(8'd0, 8'd1, 8'd2);
        push3(8'd3, 8'd4, 8'd4);
        push3(8'hFE, 8'hFF, 8'h00);
        push3(8'h10, 8'h11, 8'h11);
        go();
        run_instr(25, "wrap_jump");
        run_instr(25, "wrap");
        total++;
        if (mem[0][4] !== 8'hFF || mem[0][17] !== 8'd3) begin
            bad++;
            $display("FAIL wrap_mem: mem[04]=%02h mem[11]=%02h, required FF and 03", mem[0][4], mem[0][17]);
        end
        check_drained("wrap");
        check_fetch_pc(8'h01, "wrap_pc");
    endtask

    task automatic test_back_to_back();
        start_test();
        mem[0][0] = 8'd10; mem[0][1] = 8'd11; mem[0][2] = 8'd3;
        mem[0][3] = 8'd11; mem[0][4] = 8'd12; mem[0][5] = 8'd9;
        mem[0][10] = 8'd3; mem[0][11] = 8'd5; mem[0][12] = 8'd1;
        push3(8'd0, 8'd1, 8'd2);
        push3(8'd10, 8'd11, 8'd11);
        push3(8'd3, 8'd4, 8'd5);
        push3(8'd11, 8'd12, 8'd12);
        go();
        run_instr(25, "b2b_first");
        run_instr(25, "b2b_second");
        total++;
        if (mem[0][11] !== 8'd2 || mem[0][12] !== 8'hFF) begin
            bad++;
            $display("FAIL b2b_mem: mem[11]=%02h mem[12]=%02h, required 02 and FF", mem[0][11], mem[0][12]);
        end
        check_drained("b2b");
        check_fetch_pc(8'd9, "b2b_pc");
    endtask

    task automatic test_halt();
        int n;
        int low;
        start_test();
        mem[0][0] = 8'd3; mem[0][1] = 8'd4; mem[0][2] = 8'h30;
        mem[0][3] = 8'd1; mem[0][4] = 8'd0;
        mem[0][48] = 8'd10; mem[0][49] = 8'd11; mem[0][50] = 8'h30;
        mem[0][10] = 8'd7; mem[0][11] = 8'd5;
        push3(8'd0, 8'd1, 8'd2);
        push3(8'd3, 8'd4, 8'd4);
        push3(8'h30, 8'h31, 8'h32);
        push3(8'd10, 8'd11, 8'd11);
        go();
        run_instr(25, "halt_jump");
        n = 0;
        while (halted[0] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        total++;
        if (halted[0] !== 1'b1) begin
            bad++;
            $display("FAIL halt_reached: halted=%b after %0d cycles, required 1", halted[0], n);
        end
        low = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (halted[0] !== 1'b1 || dbg_state[0] !== 5'd25) low++;
        end
        total++;
        if (low != 0) begin
            bad++;
            $display("FAIL halt_stays: left halt in %0d of 10 cycles, required 0", low);
        end
        total++;
        if ({mem_oe_n[0], mem_we_n[0], out_stb[0], mem_latch[0], bus_oe[0]} !==
            {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL halt_outputs: oe_n=%b we_n=%b stb=%b latch=%b bus_oe=%02h, required 0/1/0/0/00",
                     mem_oe_n[0], mem_we_n[0], out_stb[0], mem_latch[0], bus_oe[0]);
        end
        total++;
        if (mem[0][11] !== 8'hFE) begin
            bad++;
            $display("FAIL halt_mem: mem[11]=%02h, required FE", mem[0][11]);
        end
        check_drained("halt");
    endtask

    // Reset landing in state 22 or 23 must cancel the pending write.
    task automatic test_reset_midwrite();
        int n;
        logic [4:0] at_state;
        for (int s = 22; s <= 23; s++) begin
            at_state = 5'(s);
            start_test();
            mem[0][0] = 8'd10; mem[0][1] = 8'd11; mem[0][2] = 8'd20;
            mem[0][10] = 8'd3; mem[0][11] = 8'd5;
            push3(8'd0, 8'd1, 8'd2);
            push3(8'd10, 8'd11, 8'd11);
            go();
            n = 0;
            while (dbg_state[0] !== at_state && n < 40) begin
                step();
                n++;
            end
            reset = 1'b1;
            step();
            total++;
            if ({dbg_state[0], mem_we_n[0], bus_out[0], mem_latch[0]} !== {5'd0, 1'b1, 8'h00, 1'b0}) begin
                bad++;
                $display("FAIL rst_in_%0d: state=%0d we_n=%b bus_out=%02h latch=%b, required 0/1/00/0",
                         s, dbg_state[0], mem_we_n[0], bus_out[0], mem_latch[0]);
            end
            repeat (3) step();
            total++;
            if (we_low[0] != 0 || mem[0][11] !== 8'd5) begin
                bad++;
                $display("FAIL rst_in_%0d_mem: we_low=%0d mem[11]=%02h, required 0 and 05",
                         s, we_low[0], mem[0][11]);
            end
            check_drained("rst_mid");
        end
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b1;
        chk_on = 1'b0;
        stb_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            lat[k] = '0;
            prev_latch[k] = 1'b0;
            we_low[k] = 0;
        end
        test_reset();
        test_basic();
        test_branch_taken();
        test_out_port();
        test_wrap();
        test_back_to_back();
        test_halt();
        test_reset_midwrite();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
